// File: rtl/fetch_decode_ctrl.sv
// RV32I fetch/decode/sequencing controller; CTRL_MISALIGN_TRAP_EN traps misaligned jump targets.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), plus one per imem_ack wait cycle.
// Backpressure: imem_req/imem_addr stay stable until imem_ack; HALT exits only through reset.
module fetch_decode_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [22:0] cword,
  output logic [31:0] pc,
  output logic [31:0] imm,
  input  logic [31:0] r_for_pc,
  input  logic [3:0]  funit_ZCNVFlags,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  typedef struct packed {
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       fun7;
    logic [2:0] fun3;
    logic [3:0] inst_type;
  } cword_t;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  localparam cword_t BUBBLE = 23'h000006;

  localparam logic [3:0] T_BRANCH = 4'd6;
  localparam logic [3:0] T_JALR   = 4'd7;
  localparam logic [3:0] T_JAL    = 4'd8;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  cword_t      cword_q, cword_d;
  logic [31:0] imm_q, imm_d;
  logic [1:0]  trap_q, trap_d;

  // Decode of the latched instruction word.
  logic [6:0]  opcode;
  logic [3:0]  dec_type;
  logic        dec_legal;
  logic        dec_sys;
  logic [31:0] dec_imm;
  cword_t      dec_cword;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_q[6:0];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    dec_type  = 4'd0;
    dec_legal = 1'b1;
    dec_sys   = 1'b0;
    dec_imm   = 32'h0;
    case (opcode)
      7'b0000011: begin dec_type = 4'd0; dec_imm = imm_i; end
      7'b0010011: begin dec_type = 4'd1; dec_imm = imm_i; end
      7'b0100011: begin dec_type = 4'd2; dec_imm = imm_s; end
      7'b0110011: begin dec_type = 4'd3; dec_imm = 32'h0; end
      7'b0110111: begin dec_type = 4'd4; dec_imm = imm_u; end
      7'b0010111: begin dec_type = 4'd5; dec_imm = imm_u; end
      7'b1100011: begin dec_type = T_BRANCH; dec_imm = imm_b; end
      7'b1100111: begin dec_type = T_JALR;   dec_imm = imm_i; end
      7'b1101111: begin dec_type = T_JAL;    dec_imm = imm_j; end
      7'b1110011: begin dec_legal = 1'b0; dec_sys = 1'b1; end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_cword.rs2       = instr_q[24:20];
    dec_cword.rs1       = instr_q[19:15];
    dec_cword.rd        = instr_q[11:7];
    dec_cword.fun7      = instr_q[30];
    dec_cword.fun3      = instr_q[14:12];
    dec_cword.inst_type = dec_type;
  end

  // Next-PC evaluation during EXEC.
  logic        flag_z, flag_c, flag_n, flag_v;
  logic        is_branch, is_jal, is_jalr;
  logic        br_taken, br_bad, is_jump;
  logic [31:0] raw_npc, npc;
  logic        misalign;

  assign {flag_z, flag_c, flag_n, flag_v} = funit_ZCNVFlags;
  assign is_branch = (cword_q.inst_type == T_BRANCH);
  assign is_jal    = (cword_q.inst_type == T_JAL);
  assign is_jalr   = (cword_q.inst_type == T_JALR);

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (cword_q.fun3)
      3'b000:  br_taken = flag_z;
      3'b001:  br_taken = !flag_z;
      3'b100:  br_taken = flag_n ^ flag_v;
      3'b101:  br_taken = !(flag_n ^ flag_v);
      3'b110:  br_taken = !flag_c;
      3'b111:  br_taken = flag_c;
      default: br_bad   = is_branch;
    endcase
  end

  assign is_jump = is_jal || is_jalr || (is_branch && br_taken);

  always_comb begin
    raw_npc = pc_q + 32'd4;
    if (is_jal || (is_branch && br_taken)) raw_npc = pc_q + imm_q;
    else if (is_jalr)                      raw_npc = (r_for_pc + imm_q) & ~32'h1;
  end

`ifdef CTRL_MISALIGN_TRAP_EN
  assign misalign = (state_q == EXEC) && is_jump && (raw_npc[1:0] != 2'b00);
  assign npc      = raw_npc;
`else
  assign misalign = 1'b0;
  assign npc      = raw_npc & ~32'h3;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cword_d = cword_q;
    imm_d   = imm_q;
    trap_d  = trap_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_sys) begin
          trap_d  = 2'b01;
          state_d = HALT;
        end else if (!dec_legal) begin
          trap_d  = 2'b10;
          state_d = HALT;
        end else begin
          cword_d = dec_cword;
          imm_d   = dec_imm;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (br_bad) begin
          trap_d  = 2'b10;
          state_d = HALT;
        end else if (misalign) begin
          trap_d  = 2'b11;
          state_d = HALT;
        end else begin
          pc_d    = npc;
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cword_q <= BUBBLE;
      imm_q   <= 32'h0;
      trap_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cword_q <= cword_d;
      imm_q   <= imm_d;
      trap_q  <= trap_d;
    end
  end

  // Gating with rst keeps the request low while reset is held, without a cycle of delay on release.
  assign imem_req   = (state_q == FETCH) && rst;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign imm        = imm_q;
  assign cword      = ((state_q == EXEC) && !misalign) ? cword_q : BUBBLE;
  assign halted     = (state_q == HALT);
  assign trap_cause = trap_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl with a queue of expected decode results.
module tb_fetch_decode_ctrl;

  localparam logic [22:0] BUBBLE = 23'h000006;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [22:0] cword;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] r_for_pc = 32'h0;
  logic [3:0]  flags = 4'h0;
  logic        halted;
  logic [1:0]  trap_cause;

  fetch_decode_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .cword(cword), .pc(pc), .imm(imm),
    .r_for_pc(r_for_pc), .funit_ZCNVFlags(flags),
    .halted(halted), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] cw;
    logic [31:0] imm;
    logic        chk_imm;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one fetch: wait for the request, hold ack low for some cycles, then ack.
  task automatic fetch(input logic [31:0] addr, input int waits, input logic [31:0] instr);
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", imem_req, 1);
    chk("fetch_addr", imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, addr);
      chk("wait_cword", cword, BUBBLE);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("dec_req", imem_req, 0);
    chk("dec_cword", cword, BUBBLE);
  endtask

  task automatic step(input logic [31:0] addr, input int waits, input logic [31:0] instr,
                      input logic [22:0] ecw, input logic [31:0] eimm, input logic ci,
                      input logic [31:0] rs1v, input logic [3:0] fl, input logic [31:0] nxt);
    exp_t e;
    e.cw = ecw; e.imm = eimm; e.chk_imm = ci;
    sb.push_back(e);
    fetch(addr, waits, instr);
    r_for_pc = rs1v;
    flags    = fl;
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("exec_cword", cword, e.cw);
      if (e.chk_imm) chk("exec_imm", imm, e.imm);
    end
    @(negedge clk);
    chk("next_pc", pc, nxt);
    chk("next_addr", imem_addr, nxt);
    chk("not_halted", halted, 0);
  endtask

  // Asynchronous reset asserted between clock edges; effects must be immediate.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap_cause, 0);
    chk("rst_cword", cword, BUBBLE);
    chk("rst_imm", imm, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #12;
    chk("reset_req", imem_req, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_cword", cword, BUBBLE);
    chk("reset_imm", imm, 32'h0);
    chk("reset_halted", halted, 0);
    chk("reset_trap", trap_cause, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_req", imem_req, 1);

    //    addr      w  instr          cword       imm           ci  rs1      flags    next
    step(32'h00, 0, 32'h00500093, 23'h140101, 32'h00000005, 1, 32'h0,   4'b0000, 32'h04); // addi
    step(32'h04, 0, 32'h12345137, 23'h0D0254, 32'h12345000, 1, 32'h0,   4'b0000, 32'h08); // lui
    step(32'h08, 2, 32'hFE20AE23, 23'h083CA2, 32'hFFFFFFFC, 1, 32'h0,   4'b0000, 32'h0C); // sw
    step(32'h0C, 0, 32'h002081B3, 23'h082303, 32'h0,        0, 32'h0,   4'b0000, 32'h10); // add
    step(32'h10, 0, 32'h00000463, 23'h000806, 32'h00000008, 1, 32'h0,   4'b1000, 32'h18); // beq taken
    step(32'h18, 0, 32'h00000463, 23'h000806, 32'h00000008, 1, 32'h0,   4'b0000, 32'h1C); // beq not
    step(32'h1C, 0, 32'h00001463, 23'h000816, 32'h00000008, 1, 32'h0,   4'b0000, 32'h24); // bne taken
    step(32'h24, 0, 32'h00004463, 23'h000846, 32'h00000008, 1, 32'h0,   4'b0010, 32'h2C); // blt taken
    step(32'h2C, 0, 32'h00007463, 23'h000876, 32'h00000008, 1, 32'h0,   4'b0000, 32'h30); // bgeu not
    step(32'h30, 0, 32'hFD1FF0EF, 23'h47E1F8, 32'hFFFFFFD0, 1, 32'h0,   4'b0000, 32'h00); // jal -48
    step(32'h00, 0, 32'h000100E7, 23'h004107, 32'h0,        1, 32'h101, 4'b0000, 32'h100); // jalr

    fetch(32'h100, 0, 32'h00000073); // ecall
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ecall_halted", halted, 1);
      chk("ecall_trap", trap_cause, 2'b01);
      chk("ecall_req", imem_req, 0);
      chk("ecall_pc", pc, 32'h100);
      @(negedge clk);
    end

    pulse_reset();
    fetch(32'h0, 5, 32'h0000007F); // illegal opcode after 5 wait cycles
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("ill_halted", halted, 1);
      chk("ill_trap", trap_cause, 2'b10);
      chk("ill_req", imem_req, 0);
      chk("ill_cword", cword, BUBBLE);
      @(negedge clk);
    end

    pulse_reset();
    fetch(32'h0, 0, 32'h00002463); // branch with reserved fun3
    @(negedge clk);
    chk("badbr_cword", cword, 23'h000826);
    @(negedge clk);
    chk("badbr_halted", halted, 1);
    chk("badbr_trap", trap_cause, 2'b10);
    chk("badbr_pc", pc, 32'h0);

    pulse_reset();
    step(32'h00, 0, 32'h00500093, 23'h140101, 32'h5, 1, 32'h0, 4'b0000, 32'h04);
    fetch(32'h04, 0, 32'h00500093);
    @(negedge clk);
    chk("midexec_cword", cword, 23'h140101);
    pulse_reset();
    chk("midexec_addr", imem_addr, 32'h0);

    step(32'h00, 0, 32'h00500093, 23'h140101, 32'h5, 1, 32'h0, 4'b0000, 32'h04);
    @(negedge clk);
    chk("midfetch_req", imem_req, 1);
    chk("midfetch_addr", imem_addr, 32'h04);
    pulse_reset();

`ifdef CTRL_MISALIGN_TRAP_EN
    fetch(32'h0, 0, 32'h000100E7);
    r_for_pc = 32'h103;
    @(negedge clk);
    chk("mis_cword", cword, BUBBLE);
    @(negedge clk);
    chk("mis_halted", halted, 1);
    chk("mis_trap", trap_cause, 2'b11);
    chk("mis_pc", pc, 32'h0);
    pulse_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
